dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single-ported data memory between the CPU load/store stage (port 0) and the test/debug loader (port 1).
- Latches one request at a time and issues it to the data memory for exactly one cycle.
- Returns read data and a completion pulse to the owning port.
- Round-robin fairness. Misaligned and out-of-range accesses are blocked and reported as errors.

Parameters:
MEM_WORDS, 32, number of 32-bit words in the attached data memory; a word index >= MEM_WORDS is out of range.
ADDR_W, 32, byte address width.
DATA_W, 32, data width.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  reset, synchronous, active-high.
req0, req1  input  1 each  port request; held high, with we/addr/wdata stable, until gnt seen.
we0, we1  input  1 each  1 = write, 0 = read.
addr0, addr1  input  ADDR_W each  byte address.
wdata0, wdata1  input  DATA_W each  write data.
gnt0, gnt1  output  1 each  request accepted; high during the ISSUE cycle.
done0, done1  output  1 each  one-cycle completion pulse.
err0, err1  output  1 each  valid with done; access blocked (misaligned or out of range).
rdata0, rdata1  output  DATA_W each  read data, registered per port.
dm_addr  output  ADDR_W  to memory addr.
dm_writeData  output  DATA_W  to memory writeData.
dm_memWrite  output  1  to memory memWrite.
dm_memRead  output  1  to memory memRead.
dm_readData  input  DATA_W  from memory readData (combinational read).
stat_gnt0, stat_gnt1  output  16 each  grant counters (see Optional Feature).
stat_conflict  output  16  conflict counter (see Optional Feature).

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous, active-high.
- Reset values:
  - state=IDLE; all gnt/done/err low; rdata0=rdata1=0.
  - Round-robin pointer rr=0, meaning port 0 wins the next tie.
  - dm_memWrite=dm_memRead=0; dm_addr=dm_writeData=0; stats=0.
- FSM states: IDLE, ISSUE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise pick the winner: sole requester; on a tie, the port indicated by rr.
  - At the edge: latch owner, we, addr, wdata; go to ISSUE; set rr = ~owner.
- ISSUE:
  - gnt_owner=1 for exactly this cycle. dm_addr/dm_writeData come from the latched registers.
  - Legal access (addr[1:0]==0 and addr[ADDR_W-1:2] < MEM_WORDS): dm_memRead=~we, dm_memWrite=we.
  - Illegal access: both strobes 0.
  - At the edge:
    - Legal read: rdata_owner <= dm_readData.
    - Write: rdata unchanged.
    - done_owner <= 1 and err_owner <= illegal; state goes to IDLE.
- Outside ISSUE both strobes are 0.
- done/err are high only during the IDLE cycle that follows ISSUE.
- rdataN holds its value until that port's next legal read completes.
- Latency and throughput: req high at edge E0 -> ISSUE in cycle E0..E1 -> done high E1..E2. One access per 2 cycles.
- Requester protocol: a port may drop or change req only after seeing gnt at an edge. A req left high after gnt is treated as a new request.
- Simultaneous requests alternate strictly while both stay asserted. rr updates only on a grant.
- Reset mid-ISSUE: dm_memWrite is gated by ~rst, so no write commits on the reset edge. No done is pulsed; state returns to IDLE.
- The other port's rdata is never modified by an access.

Optional Feature:
Macro DMEM_ARB_STATS_EN.
- Defined:
  - stat_gntN increments on each edge leaving ISSUE with owner N.
  - stat_conflict increments on each IDLE edge where req0 and req1 are both high.
  - All counters saturate at 16'hFFFF and clear on rst.
- Undefined: stat_* outputs are tied to 0 and no counter logic exists.

Test Plan:
1. Reset, then port 0 writes 0xDEADBEEF at addr 0x08 and then reads 0x08. Required:
   - dm_memWrite high for exactly one cycle with dm_addr=0x08.
   - done0 pulses 2 cycles after each req; rdata0=0xDEADBEEF after the read.
   - err0=0 throughout.
2. Both ports request on the same edge after reset: port 0 reads 0x00, port 1 reads 0x04, each held until its gnt. Required:
   - Port 0 is served first; port 1's gnt comes in the next ISSUE cycle (2 cycles later).
   - rdata1 equals mem[1]; rdata0 is unchanged by port 1's access.
3. Both reqs held continuously for 8 accesses. Required: grants alternate 0,1,0,1..., and with DMEM_ARB_STATS_EN defined, stat_gnt0=stat_gnt1=4.
4. Port 1 accesses addr 0x06 (misaligned), then addr 0x80 (index 32, out of range). Required:
   - dm_memRead and dm_memWrite stay 0 for both.
   - done1 and err1 pulse together each time; rdata1 is unchanged.
5. rst asserted during the ISSUE cycle of a port 0 write of 0x12345678 to 0x10. Required:
   - The memory word at 0x10 is unchanged.
   - No done0 pulse; all outputs at reset values the next cycle.
6. Port 0 keeps req0 high after gnt0 with new addr 0x0C, port 1 idle. Required: a second access is issued 2 cycles after the first, with no stale re-issue of the first address.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, data-memory and statistics signals of dmem_arbiter
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0, req1;
   logic              we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1;
   logic              done0, done1;
   logic              err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_writeData;
   logic              dm_memWrite;
   logic              dm_memRead;
   logic [DATA_W-1:0] dm_readData;
   logic [15:0]       stat_gnt0, stat_gnt1, stat_conflict;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_readData,
      output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
             dm_addr, dm_writeData, dm_memWrite, dm_memRead,
             stat_gnt0, stat_gnt1, stat_conflict
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dm_readData,
      input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
             dm_addr, dm_writeData, dm_memWrite, dm_memRead,
             stat_gnt0, stat_gnt1, stat_conflict
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data-memory arbiter with access checking
// Optional grant/conflict counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
   parameter int MEM_WORDS = 32,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   localparam logic [ADDR_W-1:0] LP_MEM_WORDS = ADDR_W'(MEM_WORDS);

   state_t            r_state;
   logic              r_owner;
   logic              r_rr;
   logic              r_illegal;
   logic              r_gnt0, r_gnt1;
   logic              r_done0, r_done1;
   logic              r_err0, r_err1;
   logic [DATA_W-1:0] r_rdata0, r_rdata1;
   logic [ADDR_W-1:0] r_dm_addr;
   logic [DATA_W-1:0] r_dm_wdata;
   logic              r_dm_rd, r_dm_wr;

   logic              w_pick1;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_legal;

   // r_rr = 1 hands a tie to port 1; a sole requester always wins.
   assign w_pick1 = bus.req1 & (~bus.req0 | r_rr);
   assign w_we    = w_pick1 ? bus.we1    : bus.we0;
   assign w_addr  = w_pick1 ? bus.addr1  : bus.addr0;
   assign w_wdata = w_pick1 ? bus.wdata1 : bus.wdata0;
   assign w_legal = (w_addr[1:0] == 2'b00) &&
                    ({2'b00, w_addr[ADDR_W-1:2]} < LP_MEM_WORDS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_owner    <= 1'b0;
         r_rr       <= 1'b0;
         r_illegal  <= 1'b0;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_done0    <= 1'b0;
         r_done1    <= 1'b0;
         r_err0     <= 1'b0;
         r_err1     <= 1'b0;
         r_rdata0   <= '0;
         r_rdata1   <= '0;
         r_dm_addr  <= '0;
         r_dm_wdata <= '0;
         r_dm_rd    <= 1'b0;
         r_dm_wr    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done0 <= 1'b0;
               r_done1 <= 1'b0;
               r_err0  <= 1'b0;
               r_err1  <= 1'b0;
               if (bus.req0 || bus.req1) begin
                  r_owner    <= w_pick1;
                  r_rr       <= ~w_pick1;
                  r_illegal  <= ~w_legal;
                  r_gnt0     <= ~w_pick1;
                  r_gnt1     <= w_pick1;
                  r_dm_addr  <= w_addr;
                  r_dm_wdata <= w_wdata;
                  r_dm_rd    <= w_legal & ~w_we;
                  r_dm_wr    <= w_legal & w_we;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_gnt0  <= 1'b0;
               r_gnt1  <= 1'b0;
               r_dm_rd <= 1'b0;
               r_dm_wr <= 1'b0;
               if (r_dm_rd) begin
                  if (r_owner) r_rdata1 <= bus.dm_readData;
                  else         r_rdata0 <= bus.dm_readData;
               end
               if (r_owner) begin
                  r_done1 <= 1'b1;
                  r_err1  <= r_illegal;
               end else begin
                  r_done0 <= 1'b1;
                  r_err0  <= r_illegal;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt0         = r_gnt0;
   assign bus.gnt1         = r_gnt1;
   assign bus.done0        = r_done0;
   assign bus.done1        = r_done1;
   assign bus.err0         = r_err0;
   assign bus.err1         = r_err1;
   assign bus.rdata0       = r_rdata0;
   assign bus.rdata1       = r_rdata1;
   assign bus.dm_addr      = r_dm_addr;
   assign bus.dm_writeData = r_dm_wdata;
   assign bus.dm_memRead   = r_dm_rd;
   // A reset landing on the ISSUE cycle must not let the write commit.
   assign bus.dm_memWrite  = r_dm_wr & ~rst;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] r_stat_gnt0, r_stat_gnt1, r_stat_conflict;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_gnt0     <= '0;
         r_stat_gnt1     <= '0;
         r_stat_conflict <= '0;
      end else begin
         if (r_state == S_ISSUE) begin
            if (!r_owner && r_stat_gnt0 != 16'hFFFF) r_stat_gnt0 <= r_stat_gnt0 + 16'd1;
            if (r_owner && r_stat_gnt1 != 16'hFFFF)  r_stat_gnt1 <= r_stat_gnt1 + 16'd1;
         end
         if (r_state == S_IDLE && bus.req0 && bus.req1 && r_stat_conflict != 16'hFFFF)
            r_stat_conflict <= r_stat_conflict + 16'd1;
      end
   end

   assign bus.stat_gnt0     = r_stat_gnt0;
   assign bus.stat_gnt1     = r_stat_gnt1;
   assign bus.stat_conflict = r_stat_conflict;
`else
   assign bus.stat_gnt0     = '0;
   assign bus.stat_gnt1     = '0;
   assign bus.stat_conflict = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with transaction-level model
module tb_dmem_arbiter;
   localparam int MEM_WORDS = 32;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Attached single-ported memory: combinational read, write on the clock edge.
   logic [31:0] mem      [MEM_WORDS];
   logic [31:0] init_mem [MEM_WORDS];
   logic        mem_load;
   assign bus.dm_readData = mem[bus.dm_addr[6:2]];
   always @(posedge clk) begin
      if (mem_load) mem <= init_mem;
      else if (bus.dm_memWrite) mem[bus.dm_addr[6:2]] <= bus.dm_writeData;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Pending request per port, as the requester sees it.
   bit          pv  [2];
   bit          pwe [2];
   logic [31:0] pad [2];
   logic [31:0] pwd [2];

   // Reference model state.
   logic [31:0] ref_mem [MEM_WORDS];
   int          issuing;
   int          last_winner;
   bit          e_gnt [2], e_done [2], e_err [2];
   logic [31:0] e_rdata [2];
   bit          e_rd, e_wr;
   logic [31:0] e_addr, e_wdata;
   int          s_gnt [2];
   int          s_conf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit legal_f(input logic [31:0] a);
      return (a[1:0] == 2'b00) && ((a >> 2) < 32'(MEM_WORDS));
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic drive();
      bus.req0 = pv[0]; bus.we0 = pwe[0]; bus.addr0 = pad[0]; bus.wdata0 = pwd[0];
      bus.req1 = pv[1]; bus.we1 = pwe[1]; bus.addr1 = pad[1]; bus.wdata1 = pwd[1];
   endtask

   task automatic post(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
      pv[p] = 1'b1; pwe[p] = we; pad[p] = a; pwd[p] = d;
      drive();
   endtask

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 9);
      logic [31:0] a;
      if (r == 0)      a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
      else if (r == 1) a = 32'($urandom_range(32, 200)) << 2;
      else             a = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
      return a;
   endfunction

   // One clock: predict what the arbiter does at this edge, clock it, then compare.
   task automatic step();
      int fin = -1;
      e_gnt[0] = 0; e_gnt[1] = 0; e_done[0] = 0; e_done[1] = 0;
      e_err[0] = 0; e_err[1] = 0; e_rd = 0; e_wr = 0;
      if (rst) begin
         e_rdata[0] = '0; e_rdata[1] = '0;
         s_gnt[0] = 0; s_gnt[1] = 0; s_conf = 0;
         issuing = -1; last_winner = 1;
      end else if (issuing >= 0) begin
         int          p  = issuing;
         logic [31:0] a  = pad[issuing];
         bit          ok = legal_f(a);
         if (ok && !pwe[p]) e_rdata[p] = ref_mem[a[6:2]];
         if (ok && pwe[p])  ref_mem[a[6:2]] = pwd[p];
         e_done[p] = 1; e_err[p] = !ok;
         s_gnt[p]  = sat16(s_gnt[p] + 1);
         fin = p; issuing = -1;
      end else if (pv[0] || pv[1]) begin
         int w;
         bit ok;
         if (pv[0] && pv[1]) begin
            w = 1 - last_winner;
            s_conf = sat16(s_conf + 1);
         end else begin
            w = pv[0] ? 0 : 1;
         end
         last_winner = w; issuing = w;
         ok = legal_f(pad[w]);
         e_gnt[w] = 1; e_rd = ok && !pwe[w]; e_wr = ok && pwe[w];
         e_addr = pad[w]; e_wdata = pwd[w];
      end
      @(posedge clk);
      if (fin >= 0) pv[fin] = 0;
      drive();
      #1;
      chk("gnt0",  32'(bus.gnt0),  32'(e_gnt[0]));
      chk("gnt1",  32'(bus.gnt1),  32'(e_gnt[1]));
      chk("done0", 32'(bus.done0), 32'(e_done[0]));
      chk("done1", 32'(bus.done1), 32'(e_done[1]));
      chk("err0",  32'(bus.err0),  32'(e_err[0]));
      chk("err1",  32'(bus.err1),  32'(e_err[1]));
      chk("rdata0", bus.rdata0, e_rdata[0]);
      chk("rdata1", bus.rdata1, e_rdata[1]);
      chk("memRead",  32'(bus.dm_memRead),  32'(e_rd));
      chk("memWrite", 32'(bus.dm_memWrite), 32'(e_wr));
      if (e_gnt[0] || e_gnt[1]) begin
         chk("dm_addr",  bus.dm_addr,      e_addr);
         chk("dm_wdata", bus.dm_writeData, e_wdata);
      end
`ifdef DMEM_ARB_STATS_EN
      chk("stat_gnt0",     32'(bus.stat_gnt0),     32'(s_gnt[0]));
      chk("stat_gnt1",     32'(bus.stat_gnt1),     32'(s_gnt[1]));
      chk("stat_conflict", 32'(bus.stat_conflict), 32'(s_conf));
`else
      chk("stat_gnt0",     32'(bus.stat_gnt0),     32'd0);
      chk("stat_gnt1",     32'(bus.stat_gnt1),     32'd0);
      chk("stat_conflict", 32'(bus.stat_conflict), 32'd0);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pv[0] = 0; pv[1] = 0;
      drive();
      step();
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] saved;
      issuing = -1; last_winner = 1;
      for (int i = 0; i < MEM_WORDS; i++) init_mem[i] = $urandom;
      ref_mem = init_mem;
      for (int p = 0; p < 2; p++) begin
         pv[p] = 0; pwe[p] = 0; pad[p] = '0; pwd[p] = '0;
         e_rdata[p] = '0; s_gnt[p] = 0;
      end
      s_conf = 0; e_addr = '0; e_wdata = '0;
      mem_load = 1'b1;
      rst = 1'b1;
      drive();
      step();
      step();
      mem_load = 1'b0;
      rst = 1'b0;
      step();

      // Port 0 write then read back of word 0x08.
      post(0, 1'b1, 32'h08, 32'hDEADBEEF);
      step(); step();
      post(0, 1'b0, 32'h08, 32'h0);
      step(); step();
      chk("t1_rdata0", bus.rdata0, 32'hDEADBEEF);
      step();

      // Simultaneous first requests after reset: port 0 first.
      do_reset();
      post(0, 1'b0, 32'h00, 32'h0);
      post(1, 1'b0, 32'h04, 32'h0);
      step(); step(); step(); step();
      chk("t2_rdata1", bus.rdata1, init_mem[1]);
      chk("t2_rdata0", bus.rdata0, init_mem[0]);
      step();

      // Both ports held continuously for eight accesses.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         for (int p = 0; p < 2; p++)
            if (!pv[p]) post(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, MEM_WORDS - 1)) << 2, $urandom);
         step();
      end
`ifdef DMEM_ARB_STATS_EN
      chk("t3_stat_gnt0", 32'(bus.stat_gnt0), 32'd4);
      chk("t3_stat_gnt1", 32'(bus.stat_gnt1), 32'd4);
`endif
      pv[0] = 0; pv[1] = 0; drive();
      step();

      // Blocked accesses from port 1.
      saved = e_rdata[1];
      post(1, 1'b0, 32'h06, 32'h0);
      step(); step();
      post(1, 1'b1, 32'h80, 32'hA5A5A5A5);
      step(); step();
      chk("t4_rdata1", bus.rdata1, saved);
      step();

      // Reset on the ISSUE cycle of a write.
      saved = ref_mem[4];
      post(0, 1'b1, 32'h10, 32'h12345678);
      step();
      rst = 1'b1;
      pv[0] = 0; drive();
      step();
      rst = 1'b0;
      chk("t5_mem10", mem[4], saved);
      step();

      // Back-to-back requests from port 0 with a new address.
      post(0, 1'b0, 32'h04, 32'h0);
      step(); step();
      post(0, 1'b0, 32'h0C, 32'h0);
      step();
      chk("t6_gnt0", 32'(bus.gnt0), 32'd1);
      chk("t6_addr", bus.dm_addr, 32'h0C);
      step(); step();

      // Randomized traffic from both ports.
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++)
            if (!pv[p] && $urandom_range(0, 2) != 0)
               post(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         step();
      end
      pv[0] = 0; pv[1] = 0; drive();
      step(); step(); step();

      for (int i = 0; i < MEM_WORDS; i++) chk("mem_final", mem[i], ref_mem[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
